tmds_encoder: RTL
=================

# tmds_encoder

Per-channel 8b/10b TMDS encoder for the HDMI/DVI output path. It sits between the pixel/sync generation stage (display timing plus pattern source) and the 10:1 DDR serializer that runs on the 5x clock. One instance per TMDS lane: blue carries hsync/vsync on its control bits, green and red carry 2'b00. It converts each pixel-clock beat of 8-bit colour or 2-bit control into a DC-balanced 10-bit symbol, tracking running disparity across the active line.

## Interface
Parameters:
- None.

Ports:
- i_pixel_clk  in  1  pixel clock (25.2 MHz for 640x480).
- i_reset_n  in  1  reset; asynchronous assert, active-low. Release is synchronized externally to i_pixel_clk.
- i_de  in  1  display enable; 1 = video data period, 0 = control period.
- i_data  in  8  colour component, used when i_de=1.
- i_ctrl  in  2  {c1,c0} control bits, used when i_de=0. Blue lane gets {vsync,hsync}.
- o_tmds  out  10  encoded symbol, registered; bit 0 is transmitted first.

## Operation
Stage 1 (registered): transition minimisation.
- n1d = popcount(i_data).
- Use XNOR when n1d>4, or when n1d==4 and i_data[0]==0. Otherwise use XOR.
- Build the intermediate word: q_m[0]=i_data[0]; q_m[i]=q_m[i-1] op i_data[i] for i=1..7.
- q_m[8]=1 for XOR, 0 for XNOR.
- Register q_m[8:0], popcount n1=popcount(q_m[7:0]), i_de and i_ctrl.

Stage 2 (registered): DC balance. Uses the stage-1 registered values. n0=8-n1. cnt is a 5-bit signed running disparity, always even, bounded to ±10.
- de=0:
  - o_tmds = control symbol: 00→10'b1101010100 (0x354), 01→10'b0010101011 (0x0AB), 10→10'b0101010100 (0x154), 11→10'b1010101011 (0x2AB).
  - cnt←0.
- de=1, case A (cnt==0 or n1==n0):
  - o_tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - cnt += q_m[8] ? (n1-n0) : (n0-n1).
- de=1, case B ((cnt>0 and n1>n0) or (cnt<0 and n0>n1)):
  - o_tmds = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2·q_m[8] + (n0-n1).
- de=1, case C (otherwise):
  - o_tmds = {0, q_m[8], q_m[7:0]}.
  - cnt += -2·(~q_m[8]) + (n1-n0).
- Arithmetic: all disparity math is 5-bit signed. Never let it saturate or wrap within the ±10 bound.

Boundary conditions:
- First active pixel after blanking always starts from cnt=0.
- A de 1→0 transition outputs the control symbol and clears cnt on the same edge.
- A de 0→1 transition uses cnt=0 for that first pixel.
- i_data is ignored when de=0. i_ctrl is ignored when de=1.

## Timing
- Latency: inputs sampled at rising edge k appear on o_tmds after rising edge k+1 (2-register pipeline). i_de and i_ctrl are delayed identically to i_data.
- Throughput: one symbol per clock, no stalls, no handshake.
- Reset while asserted:
  - o_tmds=0x354 (control 00) immediately, asynchronously.
  - All stage-1 registers clear (de=0, ctrl=00, q_m=0).
  - cnt=0.
- Reset asserted mid-line: the same values apply at once.
- After release: the first valid encoded input appears 2 edges later. Until then the output holds 0x354.

## Test plan
- Reset: hold i_reset_n=0 with random inputs → o_tmds=0x354. Release with de=0, ctrl=00 → o_tmds stays 0x354.
- Control codes: de=0, ctrl stepped 00/01/10/11 on consecutive cycles → o_tmds 0x354, 0x0AB, 0x154, 0x2AB, each 2 cycles after its input.
- Zero stream: after blanking, de=1 with data 0x00 for 3 pixels → o_tmds 0x100, 0x3FF, 0x100; internal cnt goes -8, +2, -6.
- Full and balanced: from blanking, data 0xFF → 0x200 (cnt -8). From blanking, data 0x55 → 0x133 (cnt stays 0).
- Disparity reset: data 0x00 (cnt -8), then de=0 for one cycle, then data 0x00 → 0x100, control symbol, 0x100 (not 0x3FF).
- Random soak: 640 random active pixels per line with blanking between lines, compared against a reference encoder model → all symbols match, |cnt|≤10, and every 10-bit data symbol decodes back to its input byte.

Source files
------------

// File: rtl/tmds_encoder.sv
// Per-lane 8b/10b TMDS encoder: a transition-minimisation stage followed by a
// DC-balance stage that tracks running disparity across each active line.
module tmds_encoder (
    input  logic       i_pixel_clk,
    input  logic       i_reset_n,
    input  logic       i_de,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    output logic [9:0] o_tmds
);

    localparam logic [9:0] CTRL_SYM_00 = 10'h354;
    localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
    localparam logic [9:0] CTRL_SYM_10 = 10'h154;
    localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // XNOR chaining is chosen for dense words so the result has fewer transitions.
    function automatic logic [8:0] build_q_m(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic [8:0] w_q_m;
    logic [8:0] r_q_m;
    logic [3:0] r_n1;
    logic       r_de;
    logic [1:0] r_ctrl;

    assign w_q_m = build_q_m(i_data);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q_m  <= '0;
            r_n1   <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_q_m  <= w_q_m;
            r_n1   <= popcount8(w_q_m[7:0]);
            r_de   <= i_de;
            r_ctrl <= i_ctrl;
        end
    end

    logic signed [4:0] r_cnt;
    logic        [9:0] r_tmds;
    logic signed [4:0] w_n1s;
    logic signed [4:0] w_n0s;
    logic signed [4:0] w_diff;
    logic              w_case_a;
    logic              w_case_b;
    logic signed [4:0] w_cnt_next;
    logic        [9:0] w_tmds_next;

    // Disparity terms stay within +/-8 and cnt within +/-10, so 5-bit signed never wraps.
    assign w_n1s    = signed'({1'b0, r_n1});
    assign w_n0s    = 5'sd8 - w_n1s;
    assign w_diff   = w_n1s - w_n0s;
    assign w_case_a = (r_cnt == 5'sd0) || (r_n1 == 4'd4);
    assign w_case_b = (!r_cnt[4] && (r_n1 > 4'd4)) || (r_cnt[4] && (r_n1 < 4'd4));

    // NOTE: defaults are assigned first so no path leaves an output unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_tmds_next = CTRL_SYM_00;
        w_cnt_next  = 5'sd0;
        if (!r_de) begin
            unique case (r_ctrl)
                2'b00: w_tmds_next = CTRL_SYM_00;
                2'b01: w_tmds_next = CTRL_SYM_01;
                2'b10: w_tmds_next = CTRL_SYM_10;
                2'b11: w_tmds_next = CTRL_SYM_11;
            endcase
        end else if (w_case_a) begin
            w_tmds_next = {~r_q_m[8], r_q_m[8], r_q_m[8] ? r_q_m[7:0] : ~r_q_m[7:0]};
            w_cnt_next  = r_q_m[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (w_case_b) begin
            w_tmds_next = {1'b1, r_q_m[8], ~r_q_m[7:0]};
            w_cnt_next  = r_cnt + (r_q_m[8] ? 5'sd2 : 5'sd0) - w_diff;
        end else begin
            w_tmds_next = {1'b0, r_q_m[8], r_q_m[7:0]};
            w_cnt_next  = r_cnt - (r_q_m[8] ? 5'sd0 : 5'sd2) + w_diff;
        end
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tmds <= CTRL_SYM_00;
            r_cnt  <= 5'sd0;
        end else begin
            r_tmds <= w_tmds_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign o_tmds = r_tmds;

endmodule
